// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth encoder.
//
// Contents:
//   BoothWidth   - default operand width (even)
//   BoothGroups  - Booth groups / partial products for BoothWidth
//   BoothTagW    - default sideband tag width
//   booth_ctrl_t - per-group select controls {single, double, negate}
//   booth_encode3 - recodes one overlapping 3-bit window into booth_ctrl_t
package booth_pkg;

    localparam int unsigned BoothWidth  = 8;
    localparam int unsigned BoothGroups = BoothWidth / 2;
    localparam int unsigned BoothTagW   = 4;

    // single : partial product is +/-Y
    // double : partial product is +/-2Y
    // negate : partial product is negated (applied downstream)
    typedef struct packed {
        logic single;
        logic double;
        logic negate;
    } booth_ctrl_t;

    // Window {b2, b1, b0} = {x[2i+1], x[2i], x[2i-1]} encodes the digit -2*b2 + b1 + b0.
    // Digit zero (000 and 111) yields all-zero controls, so 111 never asks for a -0.
    function automatic booth_ctrl_t booth_encode3(input logic b2, input logic b1,
                                                  input logic b0);
        booth_ctrl_t ctrl;
        ctrl.single = b1 ^ b0;
        ctrl.double = (b2 & ~b1 & ~b0) | (~b2 & b1 & b0);
        ctrl.negate = b2 & ~(b1 & b0);
        return ctrl;
    endfunction

endpackage

// File: rtl/booth_group_enc.sv
// Radix-4 Booth encoder for one group.
//
// Purely combinational; one instance per Booth group.
//
// Ports:
//   bits_i [2:0] - window {x[2i+1], x[2i], x[2i-1]} (x[-1] tied to 0 by the parent)
//   ctrl_o       - {single, double, negate} controls for this group
module booth_group_enc
    import booth_pkg::*;
(
    input  logic [2:0]  bits_i,
    output booth_ctrl_t ctrl_o
);

    always_comb begin
        ctrl_o = booth_encode3(bits_i[2], bits_i[1], bits_i[0]);
    end

endmodule

// File: rtl/booth_encode_stage.sv
// Radix-4 Booth encoder and operand pipeline for the signed multiplier.
//
// Two-stage elastic pipeline:
//   S1 (capture) registers X, Y and tag on an input handshake.
//   S2 (encode)  registers the per-group Booth controls, Y, the Y == most-negative flag
//                and the tag. All outputs come straight from S2 flops.
// Full throughput with out_ready held high; latency is two cycles from accept to out_valid.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-high reset; drops everything in flight
//   in_valid   - X/Y/tag offered this cycle
//   in_ready   - stage can accept (combinationally depends on out_ready)
//   in_x       - signed multiplier, Booth recoded
//   in_y       - signed multiplicand
//   in_tag     - sideband tag, passed through unchanged
//   out_valid  - encoded result valid
//   out_ready  - downstream accepts
//   out_single - bit i: group i selects +/-Y
//   out_double - bit i: group i selects +/-2Y
//   out_negate - bit i: group i negates its partial product
//   out_y      - registered multiplicand aligned with the controls
//   out_ymin   - out_y is the most negative value (100..0)
//   out_tag    - tag aligned with the controls
module booth_encode_stage
    import booth_pkg::*;
#(
    parameter  int unsigned WIDTH  = BoothWidth,
    parameter  int unsigned TAG_W  = BoothTagW,
    localparam int unsigned GROUPS = WIDTH / 2
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_x,
    input  logic [WIDTH-1:0]  in_y,
    input  logic [TAG_W-1:0]  in_tag,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [GROUPS-1:0] out_single,
    output logic [GROUPS-1:0] out_double,
    output logic [GROUPS-1:0] out_negate,
    output logic [WIDTH-1:0]  out_y,
    output logic              out_ymin,
    output logic [TAG_W-1:0]  out_tag
);

    // Odd widths would leave a dangling multiplier bit outside every group.
    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : gen_width_check
        $error("booth_encode_stage: WIDTH must be even and at least 2");
    end

    localparam logic [WIDTH-1:0] YMinValue = {1'b1, {(WIDTH - 1){1'b0}}};

    // ------------------------------------------------------------------
    // Handshake / advance control
    // ------------------------------------------------------------------
    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic s2_free;
    logic s2_load;
    logic s1_accept;

    // S2 can take a new entry when empty or when its current entry leaves this cycle.
    assign s2_free   = ~v2_q | out_ready;
    assign s2_load   = v1_q & s2_free;
    assign in_ready  = ~v1_q | s2_free;
    assign s1_accept = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Stage S1: captured operands
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] x1_q, x1_d;
    logic [WIDTH-1:0] y1_q, y1_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;

    // ------------------------------------------------------------------
    // Booth recoding of the S1 multiplier
    // ------------------------------------------------------------------
    // x[-1] = 0 is appended below bit 0 so group i reads x_ext[2i+2:2i].
    logic [WIDTH:0]                  x_ext;
    booth_ctrl_t [GROUPS-1:0]        grp_ctrl;
    logic [GROUPS-1:0]               enc_single;
    logic [GROUPS-1:0]               enc_double;
    logic [GROUPS-1:0]               enc_negate;

    assign x_ext = {x1_q, 1'b0};

    for (genvar g = 0; g < GROUPS; g++) begin : gen_group
        booth_group_enc u_group_enc (
            .bits_i (x_ext[2*g+2 -: 3]),
            .ctrl_o (grp_ctrl[g])
        );
    end

    // Regroup the per-group structs into per-control vectors for the output ports.
    always_comb begin
        enc_single = '0;
        enc_double = '0;
        enc_negate = '0;
        for (int unsigned g = 0; g < GROUPS; g++) begin
            enc_single[g] = grp_ctrl[g].single;
            enc_double[g] = grp_ctrl[g].double;
            enc_negate[g] = grp_ctrl[g].negate;
        end
    end

    // ------------------------------------------------------------------
    // Stage S2: encoded controls and aligned operand
    // ------------------------------------------------------------------
    logic [GROUPS-1:0] single_q, single_d;
    logic [GROUPS-1:0] double_q, double_d;
    logic [GROUPS-1:0] negate_q, negate_d;
    logic [WIDTH-1:0]  y2_q, y2_d;
    logic              ymin_q, ymin_d;
    logic [TAG_W-1:0]  tag2_q, tag2_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        v1_d   = v1_q;
        x1_d   = x1_q;
        y1_d   = y1_q;
        tag1_d = tag1_q;

        // A fresh accept wins over the move-out, so a full pipe shifts without a bubble.
        if (s1_accept) begin
            v1_d   = 1'b1;
            x1_d   = in_x;
            y1_d   = in_y;
            tag1_d = in_tag;
        end else if (s2_load) begin
            v1_d   = 1'b0;
        end
    end

    always_comb begin
        v2_d     = v2_q;
        single_d = single_q;
        double_d = double_q;
        negate_d = negate_q;
        y2_d     = y2_q;
        ymin_d   = ymin_q;
        tag2_d   = tag2_q;

        if (s2_load) begin
            v2_d     = 1'b1;
            single_d = enc_single;
            double_d = enc_double;
            negate_d = enc_negate;
            y2_d     = y1_q;
            ymin_d   = (y1_q == YMinValue);
            tag2_d   = tag1_q;
        end else if (out_ready) begin
            // Entry consumed with nothing behind it; data is left as-is, only valid drops.
            v2_d     = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q     <= 1'b0;
            x1_q     <= '0;
            y1_q     <= '0;
            tag1_q   <= '0;
            v2_q     <= 1'b0;
            single_q <= '0;
            double_q <= '0;
            negate_q <= '0;
            y2_q     <= '0;
            ymin_q   <= 1'b0;
            tag2_q   <= '0;
        end else begin
            v1_q     <= v1_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            tag1_q   <= tag1_d;
            v2_q     <= v2_d;
            single_q <= single_d;
            double_q <= double_d;
            negate_q <= negate_d;
            y2_q     <= y2_d;
            ymin_q   <= ymin_d;
            tag2_q   <= tag2_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: S2 flops only
    // ------------------------------------------------------------------
    assign out_valid  = v2_q;
    assign out_single = single_q;
    assign out_double = double_q;
    assign out_negate = negate_q;
    assign out_y      = y2_q;
    assign out_ymin   = ymin_q;
    assign out_tag    = tag2_q;

endmodule

// File: tb/tb_booth_encode_stage.sv
// Self-checking bench for booth_encode_stage (WIDTH=8, TAG_W=4).
// Reference: each Booth group is treated as the signed digit -2*b2 + b1 + b0 and the
// controls follow from its magnitude and sign; the pipeline is modelled as an ordered
// queue of accepted operands with their accept cycle.
module tb_booth_encode_stage;

    localparam int W  = 8;
    localparam int G  = W / 2;
    localparam int TW = 4;
    localparam int WW = 3 * G + W + 1 + TW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_x = '0;
    logic [W-1:0]  in_y = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [G-1:0]  out_single;
    logic [G-1:0]  out_double;
    logic [G-1:0]  out_negate;
    logic [W-1:0]  out_y;
    logic          out_ymin;
    logic [TW-1:0] out_tag;
    logic [WW-1:0] dut_word;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    booth_encode_stage #(
        .WIDTH (W),
        .TAG_W (TW)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_single (out_single),
        .out_double (out_double),
        .out_negate (out_negate),
        .out_y      (out_y),
        .out_ymin   (out_ymin),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    assign dut_word = {out_single, out_double, out_negate, out_y, out_ymin, out_tag};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

    // Expected output word {single, double, negate, y, ymin, tag} from signed-digit arithmetic.
    function automatic logic [WW-1:0] exp_word(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic [TW-1:0] tag);
        logic [G-1:0] s;
        logic [G-1:0] d;
        logic [G-1:0] n;
        logic         ymin;
        int           dig;
        for (int i = 0; i < G; i++) begin
            dig = int'(x[2*i]) - 2 * int'(x[2*i+1]);
            if (i > 0) dig = dig + int'(x[2*i-1]);
            s[i] = (dig == 1) || (dig == -1);
            d[i] = (dig == 2) || (dig == -2);
            n[i] = (dig < 0);
        end
        ymin = ($signed(y) == -128);
        return {s, d, n, y, ymin, tag};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_x     = 8'($urandom);
        in_y     = 8'($urandom);
        tick();
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL reset_handshake: got valid/ready %b expected 01", {out_valid, in_ready});
        else n_pass++;
        n_checks++;
        if (dut_word !== '0)
            $display("FAIL reset_data: got %h expected %h", dut_word, {WW{1'b0}});
        else n_pass++;
        tick();
    endtask

    task automatic test_directed();
        logic [W-1:0] dx[5];
        logic [W-1:0] dy[5];
        logic [WW-1:0] e;
        dx = '{8'h00, 8'h7F, 8'h80, 8'hFF, 8'h55};
        dy = '{8'h35, 8'h12, 8'h80, 8'h7F, 8'h81};
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_x      = dx[i];
            in_y      = dy[i];
            in_tag    = 4'(i + 3);
            out_ready = 1'b1;
            #1;
            tick();
            in_valid = 1'b0;
            #1;
            n_checks++;
            if (out_valid !== 1'b0)
                $display("FAIL directed_latency1 x=%h: got out_valid %b expected 0",
                         dx[i], out_valid);
            else n_pass++;
            tick();
            #1;
            e = exp_word(dx[i], dy[i], 4'(i + 3));
            n_checks++;
            if (out_valid !== 1'b1 || dut_word !== e)
                $display("FAIL directed x=%h y=%h: got valid %b word %h expected valid 1 word %h",
                         dx[i], dy[i], out_valid, dut_word, e);
            else n_pass++;
            tick();
        end
    endtask

    // Streams n operands; sweep drives x = 0..n-1, otherwise x is random.
    task automatic test_stream(input string name, input int n, input bit sweep, input int pv,
                               input int pr);
        logic [WW-1:0] q[$];
        int            qc[$];
        int            sent = 0;
        int            guard = 0;
        int            limit;
        logic          exp_v;
        logic          exp_r;
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic [TW-1:0] tg;
        limit = n * 8 + 50;
        x  = 8'($urandom);
        y  = 8'($urandom);
        tg = 4'($urandom);
        while ((sent < n || q.size() > 0) && guard < limit) begin
            in_valid  = (sent < n) && ($urandom_range(99) < pv);
            in_x      = sweep ? 8'(sent) : x;
            in_y      = y;
            in_tag    = tg;
            out_ready = ($urandom_range(99) < pr);
            #1;
            exp_v = (q.size() > 0) && (cyc >= qc[0] + 2);
            exp_r = (q.size() < 2) || out_ready;
            n_checks++;
            if (out_valid !== exp_v)
                $display("FAIL %s_out_valid cyc %0d: got %b expected %b",
                         name, cyc, out_valid, exp_v);
            else n_pass++;
            n_checks++;
            if (in_ready !== exp_r)
                $display("FAIL %s_in_ready cyc %0d: got %b expected %b",
                         name, cyc, in_ready, exp_r);
            else n_pass++;
            if (out_valid && exp_v) begin
                n_checks++;
                if (dut_word !== q[0])
                    $display("FAIL %s_data cyc %0d: got %h expected %h",
                             name, cyc, dut_word, q[0]);
                else n_pass++;
            end
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                void'(qc.pop_front());
            end
            if (in_valid && in_ready) begin
                q.push_back(exp_word(in_x, in_y, in_tag));
                qc.push_back(cyc);
                sent++;
                x  = 8'($urandom);
                y  = 8'($urandom);
                tg = 4'($urandom);
            end
            tick();
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (guard >= limit)
            $display("FAIL %s_drain: got %0d pending after %0d cycles expected 0",
                     name, q.size(), guard);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  xs[11];
        logic [W-1:0]  ys[11];
        logic [WW-1:0] e;
        for (int i = 0; i < 11; i++) begin
            xs[i] = 8'($urandom);
            ys[i] = 8'($urandom);
        end
        for (int c = 0; c < 10; c++) begin
            in_valid  = (c < 6);
            in_x      = xs[c + 1];
            in_y      = ys[c + 1];
            in_tag    = 4'(c + 1);
            out_ready = 1'b1;
            #1;
            if (c >= 2 && c < 8) begin
                e = exp_word(xs[c - 1], ys[c - 1], 4'(c - 1));
                n_checks++;
                if (out_valid !== 1'b1 || dut_word !== e)
                    $display("FAIL b2b cycle %0d: got valid %b word %h expected valid 1 word %h",
                             c, out_valid, dut_word, e);
                else n_pass++;
            end else begin
                n_checks++;
                if (out_valid !== 1'b0)
                    $display("FAIL b2b_idle cycle %0d: got out_valid %b expected 0",
                             c, out_valid);
                else n_pass++;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stall();
        logic [W-1:0]  xs[8];
        logic [W-1:0]  ys[8];
        logic [WW-1:0] e;
        int            k = 1;
        int            nx = 1;
        for (int i = 0; i < 8; i++) begin
            xs[i] = 8'($urandom);
            ys[i] = 8'($urandom);
        end
        for (int c = 0; c < 40 && nx <= 6; c++) begin
            in_valid  = (k <= 6);
            in_x      = xs[k];
            in_y      = ys[k];
            in_tag    = 4'(k);
            out_ready = (c >= 5);
            #1;
            if (c < 5) begin
                n_checks++;
                if (in_ready !== (c < 2))
                    $display("FAIL stall_in_ready cycle %0d: got %b expected %b",
                             c, in_ready, (c < 2));
                else n_pass++;
            end
            if (c >= 2 && c < 5) begin
                e = exp_word(xs[1], ys[1], 4'd1);
                n_checks++;
                if (out_valid !== 1'b1 || dut_word !== e)
                    $display("FAIL stall_hold cycle %0d: got valid %b word %h expected 1 %h",
                             c, out_valid, dut_word, e);
                else n_pass++;
            end
            if (out_valid && out_ready) begin
                e = exp_word(xs[nx], ys[nx], 4'(nx));
                n_checks++;
                if (dut_word !== e)
                    $display("FAIL stall_release #%0d: got %h expected %h", nx, dut_word, e);
                else n_pass++;
                nx++;
            end
            if (in_valid && in_ready) k++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (nx != 7)
            $display("FAIL stall_count: got %0d results expected 6", nx - 1);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_midflight();
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic [WW-1:0] e;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_x      = 8'($urandom);
        in_y      = 8'($urandom);
        in_tag    = 4'd1;
        tick();
        in_x      = 8'($urandom);
        in_tag    = 4'd2;
        tick();
        in_valid  = 1'b0;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL midreset_handshake: got valid/ready %b expected 01",
                     {out_valid, in_ready});
        else n_pass++;
        n_checks++;
        if (dut_word !== '0)
            $display("FAIL midreset_data: got %h expected %h", dut_word, {WW{1'b0}});
        else n_pass++;
        tick();
        x         = 8'($urandom);
        y         = 8'($urandom);
        in_valid  = 1'b1;
        in_x      = x;
        in_y      = y;
        in_tag    = 4'd9;
        out_ready = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0)
            $display("FAIL midreset_stale: got out_valid %b expected 0", out_valid);
        else n_pass++;
        tick();
        #1;
        e = exp_word(x, y, 4'd9);
        n_checks++;
        if (out_valid !== 1'b1 || dut_word !== e)
            $display("FAIL midreset_first: got valid %b word %h expected 1 %h",
                     out_valid, dut_word, e);
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if (out_valid !== 1'b0)
            $display("FAIL midreset_extra: got out_valid %b expected 0", out_valid);
        else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream("sweep", 256, 1'b1, 100, 100);
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_stream("random", 300, 1'b0, 70, 60);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
